// File: rtl/fetch_pkg.sv
// Shared fetch types and constants: PC/instruction widths, PC increment, buffer entry.
// No logic; no latency.
// No flow control; types only.
package fetch_pkg;
    localparam int PC_W    = 9;
    localparam int INSTR_W = 32;
    localparam logic [PC_W-1:0] PC_STEP = 9'd4;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {instr, pc} entries with an occupancy count and flush.
// Head is read straight from the storage registers; a push is visible one cycle later.
// No internal stall; the caller never pushes when full or pops when empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    output fetch_entry_t                 head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Storage, pointers and count; flush drops contents but leaves storage as-is.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one-outstanding-read issue control and a FIFO_DEPTH output buffer.
// First instruction valid 2 cycles after its imem_en; one per cycle sustained; outputs registered.
// Issue is throttled so buffered + inflight never exceeds FIFO_DEPTH; FETCH_PERF_CNT_EN adds counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = 9'h000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_en,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_pc,
    output logic [INSTR_W-1:0]  instruction,
    output logic [PC_W-1:0]     o_pc,
    output logic                o_valid,
    input  logic                i_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         o_fetch_count,
    output logic [31:0]         o_stall_count
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pending_pc;
    logic             inflight;
    logic             issue;
    logic             pop;
    logic             push;
    logic [OCC_W-1:0] occ;

    fetch_entry_t     push_entry;
    fetch_entry_t     head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    assign o_valid     = ~fifo_empty;
    assign instruction = head.instr;
    assign o_pc        = head.pc;
    assign pop         = o_valid & i_ready;

    // A redirect kills the response arriving this cycle; full is never seen with inflight set.
    assign push       = inflight & ~redirect_valid & ~fifo_full;
    assign push_entry = '{instr: imem_rdata, pc: pending_pc};

    // Slots already claimed after this cycle's pop; issue only if one remains free.
    assign occ       = {1'b0, fifo_count} + OCC_W'(inflight) - OCC_W'(pop);
    assign issue     = ~reset & ~redirect_valid & (occ < OCC_W'(FIFO_DEPTH));
    assign imem_en   = issue;
    assign imem_addr = pc;

    // PC and outstanding-read tracking; a redirect overrides any issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            pending_pc <= '0;
            inflight   <= 1'b0;
        end else if (redirect_valid) begin
            pc         <= redirect_pc;
            inflight   <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pending_pc <= pc;
                pc         <= pc + PC_STEP;
            end
        end
    end

    fetch_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

`ifdef FETCH_PERF_CNT_EN
    // Completed transfers and backpressured cycles, both free-running modulo 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_fetch_count <= '0;
            o_stall_count <= '0;
        end else begin
            if (pop) begin
                o_fetch_count <= o_fetch_count + 32'd1;
            end
            if (o_valid && !i_ready) begin
                o_stall_count <= o_stall_count + 32'd1;
            end
        end
    end
`endif
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 9'h000: PC loaded at reset.
REQ-002 Parameter FIFO_DEPTH, default 2: output buffer entries; legal values 2..4.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_en  output  1  instruction-memory read request this cycle.
REQ-006 imem_addr  output  9  byte address of the requested word; equals the current PC.
REQ-007 imem_rdata  input  32  read data, valid exactly one cycle after the imem_en cycle.
REQ-008 redirect_valid  input  1  flush and restart fetch, e.g. on branch mispredict.
REQ-009 redirect_pc  input  9  restart address; sampled when redirect_valid=1.
REQ-010 instruction  output  32  head-of-buffer instruction, consumed by the decode stage.
REQ-011 o_pc  output  9  PC of instruction.
REQ-012 o_valid  output  1  instruction/o_pc hold a valid entry.
REQ-013 i_ready  input  1  downstream accepts; a transfer occurs when o_valid=1 and i_ready=1.

Function
REQ-014 The block shall keep a PC register, a 1-bit inflight flag and a FIFO of FIFO_DEPTH {instruction, pc} entries with an occupancy count.
REQ-015 The block shall issue a read (imem_en=1) iff redirect_valid=0 and (count + inflight - pop) < FIFO_DEPTH, where pop = o_valid and i_ready.
REQ-016 On issue the block shall set inflight, latch the issued PC as pending_pc, and advance PC by 4, wrapping modulo 512.
REQ-017 In the cycle after an issue, the block shall write {imem_rdata, pending_pc} into the FIFO tail at the clock edge and clear inflight, unless the response is killed.
REQ-018 Outputs shall be driven from the registered FIFO head: first o_valid two cycles after the first imem_en; no combinational path from imem_rdata to the outputs.
REQ-019 Steady-state throughput shall be one instruction per cycle while i_ready=1.
REQ-020 instruction and o_pc shall be held stable while o_valid=1 and i_ready=0.
REQ-021 With the FIFO full and i_ready=0, imem_en shall be 0 and no entry shall be lost or overwritten.
REQ-022 A simultaneous push and pop shall leave count unchanged; a pop when empty and a push when full shall be impossible by construction.
REQ-023 A redirect shall have priority over all other events: it empties the FIFO, kills any inflight response, loads PC with redirect_pc, and blocks issue in that cycle.
REQ-024 o_valid shall be 0 in the cycle after a redirect, and the first read at redirect_pc shall issue in that same cycle.
REQ-025 Back-to-back redirects shall each take effect, with the last one winning.
REQ-026 The block shall not filter NOPs; it shall pass every fetched word.

Reset
REQ-027 While reset=1, the block shall hold PC=RESET_PC, count=0, inflight=0, o_valid=0, imem_en=0, instruction=0, o_pc=0, with the FIFO pointers at 0.
REQ-028 A reset asserted mid-operation shall discard all buffered and inflight data immediately, asynchronously.
REQ-029 Fetch shall start in the first cycle after reset deasserts.

Configuration
REQ-030 With macro FETCH_PERF_CNT_EN defined, the block shall add outputs o_fetch_count[31:0] (completed transfers) and o_stall_count[31:0] (cycles with o_valid=1 and i_ready=0).
REQ-031 Both counters shall reset to 0 and wrap at 2^32.
REQ-032 With FETCH_PERF_CNT_EN undefined, the counter ports and their logic shall be absent.

Structure
REQ-033 A shared package fetch_pkg shall hold PC_W=9, INSTR_W=32, PC_STEP=4, and typedef fetch_entry_t {instr, pc}.
REQ-034 The buffer shall be a sub-module fetch_fifo (parameterised depth, push/pop/full/empty/count); PC and issue control shall live in fetch_unit.

Verification
REQ-035 Reset release, i_ready=1, memory returning addr-indexed words: o_valid rises 2 cycles after the first imem_en, then o_pc = 0,4,8,... on consecutive cycles.
REQ-036 i_ready=0 for 5 cycles mid-stream: exactly FIFO_DEPTH entries are buffered, imem_en=0 once full, and the sequence resumes without gaps or duplicates.
REQ-037 redirect_valid=1 with redirect_pc=9'h040 while the FIFO is full and a read is inflight: next-cycle o_valid=0, and the first transfer afterward has o_pc=0x040.
REQ-038 PC=9'h1FC with i_ready=1: the following fetched o_pc is 9'h000 (wrap).
REQ-039 reset asserted while count=2 and inflight=1: o_valid=0 immediately, and after release the first o_pc equals RESET_PC.
REQ-040 With FETCH_PERF_CNT_EN: 10 transfers plus 3 stall cycles give o_fetch_count=10 and o_stall_count=3.
